// File: rtl/mips_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mips_ctrl_fsm -- multi-cycle MIPS control unit.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// holds the fetched word in an instruction register, and registers the
// decoded datapath controls at the end of DECODE so they stay stable until
// the next instruction is decoded.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   instr_in   instruction word from instruction memory (N bits)
//   mem_ready  memory access complete this cycle
//   alu_zero   ALU zero flag, used by BEQ in EXEC
//   ImmorReg   ALU B select: 0 = zero-extended Imm, 1 = register Qs
//   Imm        immediate field IR[15:0]
//   rs/rt/rd   register addresses IR[25:21] / IR[20:16] / IR[15:11]
//   jaddr      jump target IR[25:0]
//   alu_op     0 ADD, 1 SUB, 2 AND, 3 OR
//   reg_dst    write-register select: 1 = rd, 0 = rt
//   reg_we, mem_re, mem_we, pc_we, branch, jump, illegal   control strobes
//   state      current state encoding (FETCH=0 .. WB=4)
// ---------------------------------------------------------------------------
package the_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Instruction class; selects the path taken after EXEC.
    typedef enum logic [2:0] {
        K_ALU, K_LW, K_SW, K_BEQ, K_J, K_ILL
    } kind_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
endpackage

module mips_ctrl_fsm
    import the_pkg::*;
#(
    parameter int N       = 32,
    parameter int ImmBits = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       instr_in,
    input  logic               mem_ready,
    input  logic               alu_zero,
    output logic               ImmorReg,
    output logic [ImmBits-1:0] Imm,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [25:0]        jaddr,
    output logic [2:0]         alu_op,
    output logic               reg_dst,
    output logic               reg_we,
    output logic               mem_re,
    output logic               mem_we,
    output logic               pc_we,
    output logic               branch,
    output logic               jump,
    output logic               illegal,
    output logic [2:0]         state
);

    state_t       state_q, state_d;
    kind_t        kind_q, dec_kind;
    logic [N-1:0] ir_q;
    logic [2:0]   dec_alu_op;
    logic         dec_immor_reg, dec_reg_dst;
    logic [5:0]   opcode, funct;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign state  = state_q;

    // Decode of the held IR; only consumed while in DECODE.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        dec_kind      = K_ILL;
        dec_alu_op    = ALU_ADD;
        dec_immor_reg = 1'b1;
        dec_reg_dst   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin dec_kind = K_ALU; dec_alu_op = ALU_ADD; end
                    FN_SUB:  begin dec_kind = K_ALU; dec_alu_op = ALU_SUB; end
                    FN_AND:  begin dec_kind = K_ALU; dec_alu_op = ALU_AND; end
                    FN_OR:   begin dec_kind = K_ALU; dec_alu_op = ALU_OR;  end
                    default: dec_kind = K_ILL;
                endcase
                dec_reg_dst = (dec_kind == K_ALU);
            end
            OP_ADDI: begin dec_kind = K_ALU; dec_immor_reg = 1'b0; end
            OP_ORI:  begin dec_kind = K_ALU; dec_immor_reg = 1'b0; dec_alu_op = ALU_OR; end
            OP_LW:   begin dec_kind = K_LW;  dec_immor_reg = 1'b0; end
            OP_SW:   begin dec_kind = K_SW;  dec_immor_reg = 1'b0; end
            OP_BEQ:  begin dec_kind = K_BEQ; dec_alu_op = ALU_SUB; end
            OP_J:    dec_kind = K_J;
            default: dec_kind = K_ILL;
        endcase
    end

    // Next state and strobes.
    always_comb begin
        state_d = state_q;
        reg_we  = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        pc_we   = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_kind == K_ILL) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_ALU:       state_d = S_WB;
                    K_LW, K_SW:  state_d = S_MEM;
                    K_BEQ: begin
                        pc_we   = alu_zero;
                        branch  = alu_zero;
                        state_d = S_FETCH;
                    end
                    K_J: begin
                        pc_we   = 1'b1;
                        jump    = 1'b1;
                        state_d = S_FETCH;
                    end
                    default:     state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_re = (kind_q == K_LW);
                mem_we = (kind_q != K_LW);
                if (mem_ready)
                    state_d = (kind_q == K_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // The state register only leaves its current state at the reset
        // edge, so strobes must be squashed explicitly while rst is high.
        if (rst) begin
            reg_we  = 1'b0;
            mem_re  = 1'b0;
            mem_we  = 1'b0;
            pc_we   = 1'b0;
            branch  = 1'b0;
            jump    = 1'b0;
            illegal = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            ir_q     <= '0;
            kind_q   <= K_ALU;
            ImmorReg <= 1'b1;
            Imm      <= '0;
            rs       <= '0;
            rt       <= '0;
            rd       <= '0;
            jaddr    <= '0;
            alu_op   <= ALU_ADD;
            reg_dst  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && mem_ready)
                ir_q <= instr_in;
            if (state_q == S_DECODE) begin
                kind_q   <= dec_kind;
                ImmorReg <= dec_immor_reg;
                Imm      <= ir_q[ImmBits-1:0];
                rs       <= ir_q[25:21];
                rt       <= ir_q[20:16];
                rd       <= ir_q[15:11];
                jaddr    <= ir_q[25:0];
                alu_op   <= dec_alu_op;
                reg_dst  <= dec_reg_dst;
            end
        end
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mips_ctrl_fsm -- directed bench for mips_ctrl_fsm.
//
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// away from the rising edge. Strobes are compared as one packed vector
// {reg_we, mem_re, mem_we, pc_we, branch, jump, illegal}.
// ---------------------------------------------------------------------------
module tb_mips_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        mem_ready;
    logic        alu_zero;
    logic        ImmorReg;
    logic [15:0] Imm;
    logic [4:0]  rs, rt, rd;
    logic [25:0] jaddr;
    logic [2:0]  alu_op;
    logic        reg_dst;
    logic        reg_we, mem_re, mem_we, pc_we, branch, jump, illegal;
    logic [2:0]  state;
    logic [6:0]  strb;

    int n_total = 0;
    int n_bad   = 0;

    // Strobe patterns, bit order {reg_we,mem_re,mem_we,pc_we,branch,jump,illegal}
    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] FETCH  = 7'b0100000;
    localparam logic [6:0] FDONE  = 7'b0101000;
    localparam logic [6:0] MREAD  = 7'b0100000;
    localparam logic [6:0] MWRITE = 7'b0010000;
    localparam logic [6:0] WBACK  = 7'b1000000;
    localparam logic [6:0] BTAKEN = 7'b0001100;
    localparam logic [6:0] JTAKEN = 7'b0001010;
    localparam logic [6:0] ILL    = 7'b0000001;

    assign strb = {reg_we, mem_re, mem_we, pc_we, branch, jump, illegal};

    always #5 clk = ~clk;

    mips_ctrl_fsm #(.N(32), .ImmBits(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_in  (instr_in),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .ImmorReg  (ImmorReg),
        .Imm       (Imm),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .jaddr     (jaddr),
        .alu_op    (alu_op),
        .reg_dst   (reg_dst),
        .reg_we    (reg_we),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .pc_we     (pc_we),
        .branch    (branch),
        .jump      (jump),
        .illegal   (illegal),
        .state     (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance.
    task automatic cyc(input string tag, input logic mr, input logic az,
                       input logic [2:0] exp_st, input logic [6:0] exp_strb);
        mem_ready = mr;
        alu_zero  = az;
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_st));
        check({tag, ".strb"},  32'(strb),  32'(exp_strb));
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".immorreg"}, 32'(ImmorReg), 32'd1);
        check({tag, ".imm"},      32'(Imm),      32'd0);
        check({tag, ".rs"},       32'(rs),       32'd0);
        check({tag, ".rt"},       32'(rt),       32'd0);
        check({tag, ".rd"},       32'(rd),       32'd0);
        check({tag, ".jaddr"},    32'(jaddr),    32'd0);
        check({tag, ".alu_op"},   32'(alu_op),   32'd0);
        check({tag, ".reg_dst"},  32'(reg_dst),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        instr_in  = '0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset held: FETCH would normally raise mem_re, must stay quiet.
        cyc("rst", 1'b0, 1'b0, 3'd0, NONE);
        check_reset_values("rst");
        rst = 1'b0;

        // add $8,$9,$10
        instr_in = 32'h012A4020;
        cyc("add.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("add.d", 1'b1, 1'b0, 3'd1, NONE);
        check("add.immorreg", 32'(ImmorReg), 32'd1);
        check("add.rs",       32'(rs),       32'd9);
        check("add.rt",       32'(rt),       32'd10);
        check("add.rd",       32'(rd),       32'd8);
        check("add.alu_op",   32'(alu_op),   32'd0);
        check("add.reg_dst",  32'(reg_dst),  32'd1);
        cyc("add.e", 1'b1, 1'b0, 3'd2, NONE);
        cyc("add.w", 1'b1, 1'b0, 3'd4, WBACK);

        // addi $8,$9,5
        instr_in = 32'h21280005;
        cyc("addi.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("addi.d", 1'b1, 1'b0, 3'd1, NONE);
        check("addi.immorreg", 32'(ImmorReg), 32'd0);
        check("addi.imm",      32'(Imm),      32'h0005);
        check("addi.rt",       32'(rt),       32'd8);
        check("addi.reg_dst",  32'(reg_dst),  32'd0);
        check("addi.alu_op",   32'(alu_op),   32'd0);
        cyc("addi.e", 1'b1, 1'b0, 3'd2, NONE);
        cyc("addi.w", 1'b1, 1'b0, 3'd4, WBACK);

        // ori $10,$9,0xFF with one FETCH stall cycle
        instr_in = 32'h352A00FF;
        cyc("ori.f0", 1'b0, 1'b0, 3'd0, FETCH);
        cyc("ori.f1", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("ori.d",  1'b1, 1'b0, 3'd1, NONE);
        check("ori.alu_op", 32'(alu_op), 32'd3);
        check("ori.imm",    32'(Imm),    32'h00FF);
        cyc("ori.e",  1'b1, 1'b0, 3'd2, NONE);
        cyc("ori.w",  1'b1, 1'b0, 3'd4, WBACK);

        // lw $8,4($9) with two MEM stall cycles
        instr_in = 32'h8D280004;
        cyc("lw.f",  1'b1, 1'b0, 3'd0, FDONE);
        cyc("lw.d",  1'b1, 1'b0, 3'd1, NONE);
        check("lw.immorreg", 32'(ImmorReg), 32'd0);
        cyc("lw.e",  1'b1, 1'b0, 3'd2, NONE);
        cyc("lw.m0", 1'b0, 1'b0, 3'd3, MREAD);
        cyc("lw.m1", 1'b0, 1'b0, 3'd3, MREAD);
        cyc("lw.m2", 1'b1, 1'b0, 3'd3, MREAD);
        cyc("lw.w",  1'b1, 1'b0, 3'd4, WBACK);

        // sw, no stall: back to FETCH after MEM
        instr_in = 32'hAD280004;
        cyc("sw.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("sw.d", 1'b1, 1'b0, 3'd1, NONE);
        cyc("sw.e", 1'b1, 1'b0, 3'd2, NONE);
        cyc("sw.m", 1'b1, 1'b0, 3'd3, MWRITE);

        // beq taken
        instr_in = 32'h112A0003;
        cyc("beq1.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("beq1.d", 1'b1, 1'b0, 3'd1, NONE);
        check("beq.alu_op",   32'(alu_op),   32'd1);
        check("beq.immorreg", 32'(ImmorReg), 32'd1);
        cyc("beq1.e", 1'b1, 1'b1, 3'd2, BTAKEN);
        // beq not taken
        cyc("beq0.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("beq0.d", 1'b1, 1'b0, 3'd1, NONE);
        cyc("beq0.e", 1'b1, 1'b0, 3'd2, NONE);

        // j 0x10
        instr_in = 32'h08000010;
        cyc("j.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("j.d", 1'b1, 1'b0, 3'd1, NONE);
        check("j.jaddr", 32'(jaddr), 32'h10);
        cyc("j.e", 1'b1, 1'b0, 3'd2, JTAKEN);

        // Illegal opcode 0x3F
        instr_in = 32'hFC000000;
        cyc("ill.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("ill.d", 1'b1, 1'b0, 3'd1, ILL);
        // Illegal funct with opcode 0
        instr_in = 32'h012A4021;
        cyc("ilf.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("ilf.d", 1'b1, 1'b0, 3'd1, ILL);

        // sw stalled in MEM, then reset with mem_ready high
        instr_in = 32'hAD280004;
        cyc("swr.f",  1'b1, 1'b0, 3'd0, FDONE);
        cyc("swr.d",  1'b1, 1'b0, 3'd1, NONE);
        cyc("swr.e",  1'b1, 1'b0, 3'd2, NONE);
        cyc("swr.m",  1'b0, 1'b0, 3'd3, MWRITE);
        rst = 1'b1;
        cyc("swr.r0", 1'b1, 1'b0, 3'd3, NONE);
        cyc("swr.r1", 1'b1, 1'b0, 3'd0, NONE);
        check_reset_values("swr");
        rst = 1'b0;

        // Normal operation resumes after reset
        instr_in = 32'h012A4020;
        cyc("post.f", 1'b1, 1'b0, 3'd0, FDONE);
        cyc("post.d", 1'b1, 1'b0, 3'd1, NONE);
        cyc("post.e", 1'b1, 1'b0, 3'd2, NONE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 The block SHALL import the_pkg and use parameter N, default 32, meaning the datapath word width.
REQ-002 The block SHALL use parameter ImmBits, default 16, meaning the immediate field width.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 instr_in  input  N  instruction word from instruction memory.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 alu_zero  input  1  ALU zero flag, sampled in EXEC.
REQ-008 ImmorReg  output  1  ALU B-operand select: 0 selects the zero-extended Imm, 1 selects register Qs.
REQ-009 Imm  output  ImmBits  immediate field IR[15:0].
REQ-010 rs, rt, rd  output  5 each  register addresses IR[25:21], IR[20:16], IR[15:11].
REQ-011 jaddr  output  26  jump target IR[25:0].
REQ-012 alu_op  output  3  ALU operation code: 0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-013 reg_dst  output  1  write-register select: 1 selects rd, 0 selects rt.
REQ-014 reg_we, mem_re, mem_we, pc_we, branch, jump, illegal  output  1 each  control strobes.
REQ-015 state  output  3  current state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

Function
REQ-016 The FSM SHALL use the states FETCH, DECODE, EXEC, MEM and WB, and SHALL move between them only on rising clk.
REQ-017 FETCH SHALL assert mem_re and hold the state while mem_ready=0.
REQ-018 When mem_ready=1 in FETCH, the block SHALL load instr_in into the instruction register IR, pulse pc_we for one cycle, and go to DECODE.
REQ-019 DECODE SHALL take exactly one cycle and SHALL register all decoded outputs, which SHALL then hold stable until the next DECODE.
REQ-020 The decode table SHALL be:
- opcode 0x00 with funct 0x20/0x22/0x24/0x25 -> R-type, alu_op 0/1/2/3, ImmorReg=1, reg_dst=1.
- 0x08 ADDI -> alu_op 0, ImmorReg=0, reg_dst=0.
- 0x0D ORI -> alu_op 3, ImmorReg=0, reg_dst=0.
- 0x23 LW and 0x2B SW -> alu_op 0, ImmorReg=0.
- 0x04 BEQ -> alu_op 1, ImmorReg=1.
- 0x02 J -> ImmorReg=1.
REQ-021 Imm SHALL equal IR[15:0] for every instruction; zero extension to N bits is done downstream.
REQ-022 Any other opcode, or opcode 0 with any other funct, SHALL pulse illegal for one cycle in DECODE and return to FETCH, asserting no write strobes.
REQ-023 From EXEC, the FSM SHALL go:
- R-type, ADDI, ORI -> WB.
- LW, SW -> MEM.
- BEQ -> FETCH; pc_we and branch pulse only if alu_zero=1.
- J -> FETCH; jump and pc_we pulse.
REQ-024 MEM SHALL assert mem_re for LW or mem_we for SW and hold the state while mem_ready=0.
REQ-025 When mem_ready=1 in MEM, LW SHALL go to WB and SW SHALL go to FETCH.
REQ-026 WB SHALL assert reg_we for exactly one cycle and then go to FETCH.
REQ-027 Strobes (reg_we, mem_re, mem_we, pc_we, branch, jump, illegal) SHALL be asserted only in the states listed above and SHALL never be asserted simultaneously for mem_re and mem_we.
REQ-028 Cycle counts with mem_ready=1: R-type/ADDI/ORI SHALL take 4 cycles, LW 5, SW 4, BEQ/J 3; each cycle mem_ready=0 in FETCH or MEM SHALL add one cycle.

Reset
REQ-029 When rst=1 at a rising clk, the block SHALL enter FETCH and clear IR to 0, regardless of the current state, including mid-MEM stalls.
REQ-030 While rst=1, every strobe SHALL be 0.
REQ-031 Reset values SHALL be: ImmorReg=1, Imm=0, rs=rt=rd=0, jaddr=0, alu_op=0, reg_dst=0, state=0.
REQ-032 rst SHALL take priority over mem_ready.

Verification
REQ-033 Reset, then 0x012A4020 (add $8,$9,$10) with mem_ready=1 -> states 0,1,2,4; ImmorReg=1, rs=9, rt=10, rd=8, alu_op=0, reg_dst=1; reg_we high only in WB.
REQ-034 0x21280005 (addi $8,$9,5) -> ImmorReg=0, Imm=0x0005, rt=8, reg_dst=0; 4 cycles.
REQ-035 0x8D280004 (lw) with mem_ready low for 2 cycles in MEM -> mem_re held 3 cycles, then WB with reg_we=1; 7 cycles total.
REQ-036 0x112A0003 (beq) with alu_zero=1 -> pc_we and branch pulse in EXEC; with alu_zero=0 -> no pulse; returns to FETCH.
REQ-037 0xFC000000 (opcode 0x3F) -> illegal pulses once in DECODE, next state FETCH, with no reg_we or mem_we.
REQ-038 rst=1 asserted during a MEM stall of SW -> next cycle state=0, mem_we=0, all outputs at reset values.
